// File: rtl/jtpopeye_rom_pkg.sv
// Shared types and helpers for the Popeye ROM client slot.
package jtpopeye_rom_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} romslot_st_t;

  localparam int LINE_BYTES = 4;

  // Pick one byte out of a little-endian 32-bit line
  function automatic logic [7:0] byte_sel(input logic [31:0] line, input logic [1:0] sel);
    return line[8*sel +: 8];
  endfunction

endpackage

// File: rtl/jtpopeye_rom_line.sv
// One cached ROM line: valid bit, tag and 32-bit data with a hit compare.
module jtpopeye_rom_line #(
  parameter int TW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic [TW-1:0] wtag,
  input  logic [31:0]   wdata,
  input  logic [TW-1:0] tag,
  output logic          hit,
  output logic [31:0]   data
);

  logic          valid_reg;
  logic [TW-1:0] tag_reg;
  logic [31:0]   data_reg;

  // Line storage; clr (ROM download) wipes validity every cycle it is high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      tag_reg   <= '0;
      data_reg  <= '0;
    end else if (clr) begin
      valid_reg <= 1'b0;
    end else if (we) begin
      valid_reg <= 1'b1;
      tag_reg   <= wtag;
      data_reg  <= wdata;
    end
  end

  assign hit  = valid_reg && (tag_reg == tag);
  assign data = data_reg;

endmodule

// File: rtl/jtpopeye_rom_slot.sv
// ROM client slot: byte reads from the game turned into 32-bit SDRAM bursts,
// cached in one line (or two with LRU replacement when JTPOPEYE_ROMSLOT_DUAL_EN
// is defined).
module jtpopeye_rom_slot #(
  parameter int          AW     = 15,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  output logic [7:0]    dout,
  output logic          ok,
  output logic [21:0]   sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic [31:0]   data_read,
  input  logic          data_rdy
);

  import jtpopeye_rom_pkg::*;

  localparam int OW = $clog2(LINE_BYTES);
  localparam int TW = AW - OW;
`ifdef JTPOPEYE_ROMSLOT_DUAL_EN
  localparam int NLINES = 2;
`else
  localparam int NLINES = 1;
`endif

  logic [TW-1:0] addr_tag;
  logic [OW-1:0] addr_off;
  logic [21:0]   fetch_addr;

  assign addr_tag   = addr[AW-1:OW];
  assign addr_off   = addr[OW-1:0];
  // Each line is two 16-bit SDRAM words; address arithmetic wraps at 22 bits
  assign fetch_addr = OFFSET + 22'({addr_tag, 1'b0});

  romslot_st_t   state_reg;
  logic [TW-1:0] fill_tag_reg;
  logic          drop_reg;

  logic [NLINES-1:0] line_hit;
  logic [NLINES-1:0] line_we;
  logic [31:0]       line_data [NLINES];
  logic              hit_any;
  logic [31:0]       hit_data;
  logic              rdy_now;
  logic              fill_en;

  // Data may arrive together with the ack, so REQ also accepts it
  assign rdy_now = (((state_reg == REQ) && sdram_ack) || (state_reg == WAIT)) && data_rdy;
  assign fill_en = rdy_now && !drop_reg && !downloading;

  generate
    for (genvar gi = 0; gi < NLINES; gi++) begin : g_line
      jtpopeye_rom_line #(.TW(TW)) u_line (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (downloading),
        .we    (line_we[gi]),
        .wtag  (fill_tag_reg),
        .wdata (data_read),
        .tag   (addr_tag),
        .hit   (line_hit[gi]),
        .data  (line_data[gi])
      );
    end
  endgenerate

  // Select the data of whichever line hits (tags are unique across lines)
  always_comb begin
    hit_any  = |line_hit;
    hit_data = '0;
    for (int i = 0; i < NLINES; i++) begin
      if (line_hit[i]) hit_data = line_data[i];
    end
  end

`ifdef JTPOPEYE_ROMSLOT_DUAL_EN
  logic lru_reg;  // index of the least-recently used line, the next victim

  assign line_we = fill_en ? (lru_reg ? 2'b10 : 2'b01) : 2'b00;

  // A fill or a hit makes its line most-recently used
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lru_reg <= 1'b0;
    end else if (fill_en) begin
      lru_reg <= ~lru_reg;
    end else if (cs && hit_any && !downloading) begin
      lru_reg <= ~line_hit[1];
    end
  end
`else
  assign line_we = fill_en;
`endif

  // Request FSM: one outstanding burst; a download during it discards the fill
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      sdram_req    <= 1'b0;
      sdram_addr   <= '0;
      fill_tag_reg <= '0;
      drop_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cs && !hit_any && !downloading) begin
            state_reg    <= REQ;
            sdram_req    <= 1'b1;
            sdram_addr   <= fetch_addr;
            fill_tag_reg <= addr_tag;
            drop_reg     <= 1'b0;
          end
        end
        REQ: begin
          if (downloading) drop_reg <= 1'b1;
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state_reg <= data_rdy ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (downloading) drop_reg <= 1'b1;
          if (data_rdy) state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          sdram_req <= 1'b0;
        end
      endcase
    end
  end

  // Output byte: a fill matching the current address is forwarded straight away
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ok   <= 1'b0;
      dout <= '0;
    end else if (downloading || !cs) begin
      ok <= 1'b0;
    end else if (fill_en && (fill_tag_reg == addr_tag)) begin
      ok   <= 1'b1;
      dout <= byte_sel(data_read, addr_off);
    end else if (hit_any) begin
      ok   <= 1'b1;
      dout <= byte_sel(hit_data, addr_off);
    end else begin
      ok <= 1'b0;
    end
  end

endmodule
